// File: rtl/fxp_divider_param_pkg.sv
// Shared types and sizing helpers for the iterative fixed-point divider.
// Iteration count grows by one guard step when ROUND_EN is defined.
package fxp_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int iter_count(input int width, input int frac);
`ifdef ROUND_EN
        return width + frac + 1;
`else
        return width + frac;
`endif
    endfunction

    function automatic logic [63:0] umax(input int width);
        return (64'd1 << width) - 64'd1;
    endfunction

    function automatic logic [63:0] smax(input int width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] smin(input int width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/fxp_divider_param_if.sv
// Divider request/result bundle: operands and start in, quotient, flags and status out.
// No backpressure: start is simply ignored by the slave unless it is idle.
interface fxp_div_if #(parameter int WIDTH = 10);
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             sgn;
    logic             start;
    logic [WIDTH-1:0] q_out;
    logic             dvz;
    logic             ovf;
    logic             busy;
    logic             valid;

    modport master (output a_in, b_in, sgn, start,
                    input  q_out, dvz, ovf, busy, valid);
    modport slave  (input  a_in, b_in, sgn, start,
                    output q_out, dvz, ovf, busy, valid);
endinterface

// File: rtl/fxp_divider_param_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, try the subtract.
// Zero latency, no handshake.
module div_step #(
    parameter int WIDTH = 10
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] div_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);
    logic [WIDTH:0] shifted;

    always_comb begin
        shifted = {rem_i, bit_i};
        q_o     = (shifted >= {1'b0, div_i});
        // Remainder always stays below the divisor, so the low WIDTH bits are exact.
        rem_o   = q_o ? (shifted[WIDTH-1:0] - div_i) : shifted[WIDTH-1:0];
    end
endmodule

// File: rtl/fxp_divider_param.sv
// Iterative Q(WIDTH-FRAC).FRAC divider, one quotient bit per clock; optional ROUND_EN rounding.
// valid pulses WIDTH+FRAC(+1) cycles after start (next cycle on b==0); start ignored unless idle.
module fxp_divider_param
    import fxp_div_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int FRAC  = 4
) (
    input  logic      clk,
    input  logic      sclr,
    fxp_div_if.slave  bus
);
    localparam int N  = iter_count(WIDTH, FRAC);
    localparam int MW = WIDTH + FRAC + 1;
    localparam int CW = $clog2(N);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_CALC = CALC;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] bmag_q, bmag_d;
    logic [N-1:0]     dvd_q, dvd_d;
    logic [N-2:0]     quo_q, quo_d;
    logic             sgn_q, sgn_d;
    logic             neg_q, neg_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             dvz_q, dvz_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic [N-1:0]     q_raw;
    logic [MW-1:0]    mag;
    logic             ovf_c;
    logic [WIDTH-1:0] q_res;
    logic [WIDTH-1:0] q_sat;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .div_i (bmag_q),
        .bit_i (dvd_q[N-1]),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    always_comb begin
        a_mag = (bus.sgn && bus.a_in[WIDTH-1]) ? -bus.a_in : bus.a_in;
        b_mag = (bus.sgn && bus.b_in[WIDTH-1]) ? -bus.b_in : bus.b_in;
        q_raw = {quo_q, step_q};
`ifdef ROUND_EN
        // Guard bit adds half an LSB on the magnitude; carry may reach the overflow range.
        mag = MW'(q_raw[N-1:1]) + MW'(q_raw[0]);
`else
        mag = MW'(q_raw);
`endif
        if (!sgn_q)
            ovf_c = |mag[MW-1:WIDTH];
        else if (neg_q)
            ovf_c = (mag > MW'(smin(WIDTH)));
        else
            ovf_c = (mag > MW'(smax(WIDTH)));
        q_res = neg_q ? -mag[WIDTH-1:0] : mag[WIDTH-1:0];
        if (!sgn_q)
            q_sat = WIDTH'(umax(WIDTH));
        else
            q_sat = neg_q ? WIDTH'(smin(WIDTH)) : WIDTH'(smax(WIDTH));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        bmag_d  = bmag_q;
        dvd_d   = dvd_q;
        quo_d   = quo_q;
        sgn_d   = sgn_q;
        neg_d   = neg_q;
        q_d     = q_q;
        dvz_d   = dvz_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    sgn_d  = bus.sgn;
                    neg_d  = bus.sgn & (bus.a_in[WIDTH-1] ^ bus.b_in[WIDTH-1]);
                    bmag_d = b_mag;
                    rem_d  = '0;
                    dvd_d  = N'(a_mag) << (N - WIDTH);
                    quo_d  = '0;
                    cnt_d  = '0;
                    if (bus.b_in == '0) begin
                        state_d = ST_DONE;
                        valid_d = 1'b1;
                        dvz_d   = 1'b1;
                        ovf_d   = 1'b0;
                        if (!bus.sgn)
                            q_d = WIDTH'(umax(WIDTH));
                        else
                            q_d = bus.a_in[WIDTH-1] ? WIDTH'(smin(WIDTH)) : WIDTH'(smax(WIDTH));
                    end else begin
                        state_d = ST_CALC;
                        busy_d  = 1'b1;
                    end
                end
            end
            ST_CALC: begin
                rem_d = step_rem;
                dvd_d = dvd_q << 1;
                quo_d = q_raw[N-2:0];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    valid_d = 1'b1;
                    dvz_d   = 1'b0;
                    ovf_d   = ovf_c;
                    q_d     = ovf_c ? q_sat : q_res;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sclr) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            bmag_q  <= '0;
            dvd_q   <= '0;
            quo_q   <= '0;
            sgn_q   <= 1'b0;
            neg_q   <= 1'b0;
            q_q     <= '0;
            dvz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            bmag_q  <= bmag_d;
            dvd_q   <= dvd_d;
            quo_q   <= quo_d;
            sgn_q   <= sgn_d;
            neg_q   <= neg_d;
            q_q     <= q_d;
            dvz_q   <= dvz_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    assign bus.q_out = q_q;
    assign bus.dvz   = dvz_q;
    assign bus.ovf   = ovf_q;
    assign bus.busy  = busy_q;
    assign bus.valid = valid_q;

endmodule

// File: tb/tb_fxp_divider_param.sv
// Directed checks of fxp_divider_param at WIDTH=10, FRAC=4; expectations follow ROUND_EN.
module tb_fxp_divider_param;
    logic clk = 1'b0;
    logic sclr;
    int   n_cmp = 0;
    int   n_bad = 0;

`ifdef ROUND_EN
    localparam int NEXP = 15;
    localparam logic [9:0] Q_TWO_THIRDS = 10'h00B;
`else
    localparam int NEXP = 14;
    localparam logic [9:0] Q_TWO_THIRDS = 10'h00A;
`endif

    fxp_div_if #(.WIDTH(10)) bus ();

    fxp_divider_param #(.WIDTH(10), .FRAC(4)) dut (
        .clk  (clk),
        .sclr (sclr),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [9:0] a, input logic [9:0] b, input logic s);
        bus.a_in  = a;
        bus.b_in  = b;
        bus.sgn   = s;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        // Scramble operands so any late sampling shows up in the result.
        bus.a_in  = 10'h155;
        bus.b_in  = 10'h000;
        bus.sgn   = ~s;
    endtask

    task automatic wait_valid(output int cyc, output int bcnt);
        cyc  = 0;
        bcnt = 0;
        while (bus.valid !== 1'b1 && cyc < 200) begin
            if (bus.busy === 1'b1) bcnt++;
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic do_div(input string tag, input logic [9:0] a, input logic [9:0] b,
                          input logic s, input logic [9:0] eq, input logic edvz,
                          input logic eovf, input int elat);
        int cyc, bcnt;
        start_op(a, b, s);
        wait_valid(cyc, bcnt);
        chk({tag, ".valid"}, 32'(bus.valid), 32'd1);
        chk({tag, ".lat"},   32'(cyc),       32'(elat));
        chk({tag, ".busy"},  32'(bcnt),      32'(elat));
        chk({tag, ".q"},     32'(bus.q_out), 32'(eq));
        chk({tag, ".dvz"},   32'(bus.dvz),   32'(edvz));
        chk({tag, ".ovf"},   32'(bus.ovf),   32'(eovf));
        @(posedge clk); #1;
        chk({tag, ".pulse"}, 32'(bus.valid), 32'd0);
        chk({tag, ".hold"},  32'(bus.q_out), 32'(eq));
    endtask

    initial begin
        int cyc, bcnt, vcount;
        sclr      = 1'b1;
        bus.a_in  = '0;
        bus.b_in  = '0;
        bus.sgn   = 1'b0;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sclr = 1'b0;
        chk("rst.q",     32'(bus.q_out), 32'd0);
        chk("rst.dvz",   32'(bus.dvz),   32'd0);
        chk("rst.ovf",   32'(bus.ovf),   32'd0);
        chk("rst.busy",  32'(bus.busy),  32'd0);
        chk("rst.valid", 32'(bus.valid), 32'd0);

        do_div("u12_q25",    10'h0C0, 10'h004, 1'b0, 10'h300, 1'b0, 1'b0, NEXP);
        do_div("u_dvz",      10'h0C0, 10'h000, 1'b0, 10'h3FF, 1'b1, 1'b0, 0);
        do_div("s_dvz_pos",  10'h0C0, 10'h000, 1'b1, 10'h1FF, 1'b1, 1'b0, 0);
        do_div("s_dvz_neg",  10'h340, 10'h000, 1'b1, 10'h200, 1'b1, 1'b0, 0);
        do_div("u3p5_q25",   10'h038, 10'h004, 1'b0, 10'h0E0, 1'b0, 1'b0, NEXP);
        do_div("u_ovf",      10'h0C0, 10'h002, 1'b0, 10'h3FF, 1'b0, 1'b1, NEXP);
        do_div("s_neg",      10'h340, 10'h008, 1'b1, 10'h280, 1'b0, 1'b0, NEXP);
        do_div("s_ovf_neg",  10'h340, 10'h004, 1'b1, 10'h200, 1'b0, 1'b1, NEXP);
        do_div("s_ovf_pos",  10'h0C0, 10'h004, 1'b1, 10'h1FF, 1'b0, 1'b1, NEXP);
        do_div("s_min_ok",   10'h200, 10'h010, 1'b1, 10'h200, 1'b0, 1'b0, NEXP);
        do_div("s_min_flip", 10'h200, 10'h3F0, 1'b1, 10'h1FF, 1'b0, 1'b1, NEXP);
        do_div("two_thirds", 10'h020, 10'h030, 1'b0, Q_TWO_THIRDS, 1'b0, 1'b0, NEXP);

        // Start re-asserted mid-calculation must not disturb the running divide.
        start_op(10'h0C0, 10'h004, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("mid.busy", 32'(bus.busy), 32'd1);
        bus.a_in  = 10'h038;
        bus.b_in  = 10'h008;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_valid(cyc, bcnt);
        chk("mid.valid", 32'(bus.valid), 32'd1);
        chk("mid.lat",   32'(cyc + 4),   32'(NEXP));
        chk("mid.q",     32'(bus.q_out), 32'h300);
        // Start during the DONE cycle is dropped as well.
        bus.a_in  = 10'h038;
        bus.b_in  = 10'h004;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("done_start.busy",  32'(bus.busy),  32'd0);
        chk("done_start.valid", 32'(bus.valid), 32'd0);
        @(posedge clk); #1;
        chk("done_start.idle",  32'(bus.busy),  32'd0);

        // Leave non-zero flags behind, then abort a divide with sclr.
        do_div("pre_clr", 10'h340, 10'h004, 1'b1, 10'h200, 1'b0, 1'b1, NEXP);
        start_op(10'h0C0, 10'h004, 1'b0);
        repeat (4) begin
            @(posedge clk); #1;
        end
        sclr = 1'b1;
        @(posedge clk); #1;
        sclr = 1'b0;
        chk("clr.q",     32'(bus.q_out), 32'd0);
        chk("clr.dvz",   32'(bus.dvz),   32'd0);
        chk("clr.ovf",   32'(bus.ovf),   32'd0);
        chk("clr.busy",  32'(bus.busy),  32'd0);
        chk("clr.valid", 32'(bus.valid), 32'd0);
        vcount = 0;
        for (int i = 0; i < NEXP + 2; i++) begin
            @(posedge clk); #1;
            if (bus.valid === 1'b1 || bus.busy === 1'b1) vcount++;
        end
        chk("clr.quiet", 32'(vcount), 32'd0);

        do_div("post_clr", 10'h340, 10'h008, 1'b1, 10'h280, 1'b0, 1'b0, NEXP);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
